fb_rect_fill: RTL and testbench
===============================

Name: fb_rect_fill

Overview:
Command-driven rectangle fill engine that sits directly upstream of the double-buffered frame buffer and drives its write side. It accepts one rectangle command (origin, size, RGB565 colour), clips it to the 320x180 write space and emits one pixel write per cycle in row-major order. An optional buffer-swap pulse can follow the fill. Used for screen clears, backgrounds and solid UI boxes before sprite drawing.

Parameters:
FB_WIDTH, 320, write-space width in pixels
FB_HEIGHT, 180, write-space height in pixels
ADDR_WIDTH, 32, width of write_addr (matches frame buffer write_addr, 2*FB_SIZE)

Ports:
clk_in  input  1  system clock; also drives the frame buffer write_clk
rst_in  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine idle, will accept a command
cmd_x  input  9  rectangle left column
cmd_y  input  8  rectangle top row
cmd_w  input  9  width in pixels
cmd_h  input  8  height in pixels
cmd_color  input  16  RGB565 fill colour
cmd_swap  input  1  pulse swap_buffer after the fill
write_data  output  16  pixel colour to frame buffer
write_addr  output  ADDR_WIDTH  pixel address = 2*(y*FB_WIDTH+x)
write_enable  output  1  single-cycle write strobe per pixel
swap_buffer  output  1  single-cycle buffer swap request
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous, active-high.
- Reset: state IDLE; write_enable, swap_buffer, done, busy = 0; write_addr, write_data = 0; cmd_ready = 0 while rst_in is high. Reset mid-operation aborts immediately: no further writes, no swap.
- cmd_ready = (state==IDLE) && !rst_in. A command is accepted on a rising edge with cmd_valid && cmd_ready. All cmd_* fields are registered at acceptance; later input changes are ignored.
- States: IDLE -> SETUP -> FILL -> [SWAP] -> IDLE.
- SETUP (1 cycle): clipping.
  - Empty if cmd_x>=FB_WIDTH, cmd_y>=FB_HEIGHT, cmd_w==0 or cmd_h==0.
  - Otherwise eff_w = min(cmd_w, FB_WIDTH-cmd_x) and eff_h = min(cmd_h, FB_HEIGHT-cmd_y).
  - Base address = 2*(cmd_y*FB_WIDTH+cmd_x). This is the only multiply.
  - Exit: empty and cmd_swap -> SWAP; empty and !cmd_swap -> IDLE with done; else -> FILL.
- FILL: one write per cycle, no gaps. write_enable=1, write_data=colour, write_addr from a running register.
  - Address steps +2 per pixel.
  - At row end, next address = row_start + 2*FB_WIDTH.
  - Column and row counters are sized to hold FB_WIDTH and FB_HEIGHT.
  - After the last pixel: -> SWAP if cmd_swap, else -> IDLE with done.
- SWAP (1 cycle): swap_buffer=1, write_enable=0, then -> IDLE with done.
- Timing: acceptance edge at cycle T; SETUP occupies T+1; first write_enable in T+2. N pixels occupy T+2..T+N+1. With no swap, done and cmd_ready are high in T+N+2. With swap, swap_buffer is high in T+N+2, and done and cmd_ready are high in T+N+3.
- done is registered and coincides with the first IDLE cycle. A new command may be accepted on that same edge, so back-to-back commands lose only the SETUP cycle.
- write_enable is low outside FILL. write_addr and write_data hold their last values when idle.
- Max address is 2*(FB_WIDTH*FB_HEIGHT-1) = 115198 and never exceeds it.

Test Plan:
- Reset released, cmd (x0,y0,w2,h2,color 0xF800, swap0) -> write_enable in 4 consecutive cycles starting T+2, addrs 0,2,640,642, data 0xF800; done at T+6; no swap_buffer.
- Clip: cmd (x318,y179,w5,h5) -> exactly 2 writes, addrs 115196 and 115198; done 1 cycle after.
- Full clear (x0,y0,w320,h180,0x0000,swap1) -> 57600 contiguous writes, last addr 115198; swap_buffer for exactly one cycle at T+57602; done at T+57603.
- Empty with swap: cmd_w=0, cmd_swap=1 -> zero writes; swap_buffer at T+2; done at T+3. Repeat with cmd_x=400, cmd_swap=0 -> zero writes, done at T+2.
- Hold cmd_valid high across two commands, changing fields mid-fill -> first command unaffected; second accepted on the done cycle; its first write 2 cycles later.
- Assert rst_in during FILL of a 10x10 rect -> write_enable=0 the cycle after the reset edge; no swap_buffer, no done; cmd_ready=1 the first cycle after rst_in falls.

Source files
------------

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: command-driven solid rectangle fill engine for the frame buffer
// write side. One command (origin, size, RGB565 colour) is clipped to the
// FB_WIDTH x FB_HEIGHT write space. It then produces one pixel write per cycle
// in row-major order. An optional single-cycle buffer swap can follow the fill.
//
// Handshake: cmd_valid/cmd_ready. A command transfers on a rising edge where
// both are high. cmd_ready is high only in IDLE and outside reset. All cmd_*
// fields are captured on that edge and later changes are ignored.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_x, cmd_y              rectangle origin (column, row)
//   cmd_w, cmd_h              rectangle size in pixels
//   cmd_color                 RGB565 fill colour
//   cmd_swap                  request a swap_buffer pulse after the fill
//   write_data/addr/enable    frame buffer write port (addr = 2*(y*W+x))
//   swap_buffer               one-cycle buffer swap request
//   busy                      engine not idle
//   done                      one-cycle pulse in the first IDLE cycle after a command
module fb_rect_fill #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 180,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [8:0]            cmd_x,
  input  logic [7:0]            cmd_y,
  input  logic [8:0]            cmd_w,
  input  logic [7:0]            cmd_h,
  input  logic [15:0]           cmd_color,
  input  logic                  cmd_swap,
  output logic [15:0]           write_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  write_enable,
  output logic                  swap_buffer,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, SWAP} state_t;

  localparam logic [ADDR_WIDTH-1:0] FB_W_A     = ADDR_WIDTH'(FB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(2 * FB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] PIX_STRIDE = ADDR_WIDTH'(2);

  state_t                state_q, state_d;
  logic [8:0]            x_q, x_d, w_q, w_d;
  logic [7:0]            y_q, y_d, h_q, h_d;
  logic [15:0]           color_q, color_d;
  logic                  swap_q, swap_d;
  logic [8:0]            eff_w_q, eff_w_d, col_q, col_d;
  logic [7:0]            eff_h_q, eff_h_d, row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, row_start_q, row_start_d;
  logic [15:0]           data_q, data_d;
  logic                  done_q, done_d;

  logic [8:0]            rem_w;
  logic [7:0]            rem_h;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  last_col, last_row;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    swap_d      = swap_q;
    eff_w_d     = eff_w_q;
    eff_h_d     = eff_h_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    row_start_d = row_start_q;
    data_d      = data_q;
    done_d      = 1'b0;

    // Remaining space is only meaningful when the origin is inside the
    // write space; the empty test guards every use of it.
    rem_w     = 9'(FB_WIDTH) - x_q;
    rem_h     = 8'(FB_HEIGHT) - y_q;
    empty     = (x_q >= 9'(FB_WIDTH)) || (y_q >= 8'(FB_HEIGHT)) ||
                (w_q == 9'd0) || (h_q == 8'd0);
    base_addr = (ADDR_WIDTH'(y_q) * FB_W_A + ADDR_WIDTH'(x_q)) << 1;
    last_col  = (col_q == eff_w_q - 9'd1);
    last_row  = (row_q == eff_h_q - 8'd1);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          swap_d  = cmd_swap;
          state_d = SETUP;
        end
      end
      SETUP: begin
        eff_w_d = (w_q < rem_w) ? w_q : rem_w;
        eff_h_d = (h_q < rem_h) ? h_q : rem_h;
        col_d   = 9'd0;
        row_d   = 8'd0;
        if (empty) begin
          if (swap_q) begin
            state_d = SWAP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d     = FILL;
          addr_d      = base_addr;
          row_start_d = base_addr;
          data_d      = color_q;
        end
      end
      FILL: begin
        if (last_col) begin
          if (last_row) begin
            // Address is left on the final pixel so it holds while idle.
            if (swap_q) begin
              state_d = SWAP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            col_d       = 9'd0;
            row_d       = row_q + 8'd1;
            row_start_d = row_start_q + ROW_STRIDE;
            addr_d      = row_start_q + ROW_STRIDE;
          end
        end else begin
          col_d  = col_q + 9'd1;
          addr_d = addr_q + PIX_STRIDE;
        end
      end
      SWAP: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      swap_q      <= 1'b0;
      eff_w_q     <= '0;
      eff_h_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      row_start_q <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      swap_q      <= swap_d;
      eff_w_q     <= eff_w_d;
      eff_h_q     <= eff_h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      row_start_q <= row_start_d;
      data_q      <= data_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE) && !rst_in;
  assign write_enable = (state_q == FILL);
  assign swap_buffer  = (state_q == SWAP);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign write_addr   = addr_q;
  assign write_data   = data_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Testbench for fb_rect_fill. A table of rectangle commands has hand-computed
// pixel counts and final addresses. A scoreboard queue holds every expected
// write address. Hand-written sequences cover reset, back-to-back commands
// with cmd_valid held high, and reset in the middle of a fill.
module tb_fb_rect_fill;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [15:0] cmd_color;
  logic        cmd_swap;
  logic [15:0] write_data;
  logic [31:0] write_addr;
  logic        write_enable;
  logic        swap_buffer;
  logic        busy;
  logic        done;

  fb_rect_fill #(.FB_WIDTH(320), .FB_HEIGHT(180), .ADDR_WIDTH(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_swap(cmd_swap),
    .write_data(write_data), .write_addr(write_addr),
    .write_enable(write_enable), .swap_buffer(swap_buffer),
    .busy(busy), .done(done)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [8:0]  w;
    logic [7:0]  h;
    logic [15:0] color;
    logic        swap;
    int          exp_n;     // hand-computed pixel count after clipping
    logic [31:0] exp_last;  // hand-computed final write address (when exp_n > 0)
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_cmd(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                           input logic [7:0] h, input logic [15:0] c, input logic s);
    cmd_valid = 1'b1;
    cmd_x     = x;
    cmd_y     = y;
    cmd_w     = w;
    cmd_h     = h;
    cmd_color = c;
    cmd_swap  = s;
  endtask

  // Reference model: clipped rectangle in row-major order.
  task automatic build_expected(input vec_t v);
    int ew, eh;
    exp_q.delete();
    if (int'(v.x) < 320 && int'(v.y) < 180 && v.w != 9'd0 && v.h != 8'd0) begin
      ew = (int'(v.w) < 320 - int'(v.x)) ? int'(v.w) : 320 - int'(v.x);
      eh = (int'(v.h) < 180 - int'(v.y)) ? int'(v.h) : 180 - int'(v.y);
      for (int r = 0; r < eh; r++)
        for (int c = 0; c < ew; c++)
          exp_q.push_back(32'(2 * ((int'(v.y) + r) * 320 + int'(v.x) + c)));
    end
  endtask

  // Issue one command from an idle cycle and follow it until done. Cycle k
  // counts from the acceptance edge; k=1 is SETUP.
  task automatic run_vec(input int idx, input vec_t v);
    int n_we, first_k, last_k, swap_k, swap_cnt, done_k, exp_done;
    logic [31:0] exp_a;
    n_we = 0; first_k = -1; last_k = -1; swap_k = -1; swap_cnt = 0; done_k = -1;
    build_expected(v);
    drive_cmd(v.x, v.y, v.w, v.h, v.color, v.swap);
    check($sformatf("v%0d_ready_before", idx), 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check($sformatf("v%0d_busy_setup", idx), 32'(busy), 32'd1);
    for (int k = 1; k <= v.exp_n + 10 && done_k < 0; k++) begin
      if (write_enable) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        n_we++;
        exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check($sformatf("v%0d_addr_k%0d", idx, k), write_addr, exp_a);
        check($sformatf("v%0d_data_k%0d", idx, k), 32'(write_data), 32'(v.color));
      end
      if (swap_buffer) begin
        swap_cnt++;
        swap_k = k;
      end
      if (done) begin
        done_k = k;
        check($sformatf("v%0d_ready_at_done", idx), 32'(cmd_ready), 32'd1);
      end else begin
        tick();
      end
    end
    exp_done = v.exp_n + 2 + (v.swap ? 1 : 0);
    check($sformatf("v%0d_done_cycle", idx), 32'(done_k), 32'(exp_done));
    check($sformatf("v%0d_write_count", idx), 32'(n_we), 32'(v.exp_n));
    check($sformatf("v%0d_swap_count", idx), 32'(swap_cnt), v.swap ? 32'd1 : 32'd0);
    if (v.swap)
      check($sformatf("v%0d_swap_cycle", idx), 32'(swap_k), 32'(v.exp_n + 2));
    if (v.exp_n > 0) begin
      check($sformatf("v%0d_first_k", idx), 32'(first_k), 32'd2);
      check($sformatf("v%0d_last_k", idx), 32'(last_k), 32'(v.exp_n + 1));
      check($sformatf("v%0d_addr_hold", idx), write_addr, v.exp_last);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{9'd0,   8'd0,   9'd2,   8'd2,   16'hF800, 1'b0, 4,     32'd642};
    vecs[1] = '{9'd318, 8'd179, 9'd5,   8'd5,   16'h07E0, 1'b0, 2,     32'd115198};
    vecs[2] = '{9'd0,   8'd0,   9'd320, 8'd180, 16'h0000, 1'b1, 57600, 32'd115198};
    vecs[3] = '{9'd5,   8'd3,   9'd0,   8'd4,   16'h001F, 1'b1, 0,     32'd0};
    vecs[4] = '{9'd400, 8'd0,   9'd3,   8'd3,   16'h1234, 1'b0, 0,     32'd0};
    vecs[5] = '{9'd10,  8'd20,  9'd3,   8'd2,   16'hABCD, 1'b1, 6,     32'd13464};
    vecs[6] = '{9'd0,   8'd170, 9'd1,   8'd20,  16'h5555, 1'b0, 10,    32'd114560};
    vecs[7] = '{9'd100, 8'd180, 9'd5,   8'd5,   16'hFFFF, 1'b1, 0,     32'd0};
    vecs[8] = '{9'd319, 8'd0,   9'd511, 8'd255, 16'h0F0F, 1'b0, 180,   32'd115198};

    rst_in = 1'b1;
    drive_cmd(9'd0, 8'd0, 9'd0, 8'd0, 16'h0, 1'b0);
    cmd_valid = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_swap", 32'(swap_buffer), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", write_addr, 32'd0);
    check("rst_data", 32'(write_data), 32'd0);
    rst_in = 1'b0;
    #1;
    check("rst_release_ready", 32'(cmd_ready), 32'd1);

    // Table-driven commands, each issued from the previous done cycle
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
    tick();

    // Back-to-back with cmd_valid held high; fields change mid-fill
    drive_cmd(9'd0, 8'd0, 9'd3, 8'd1, 16'h1111, 1'b0);
    tick();
    drive_cmd(9'd2, 8'd1, 9'd2, 8'd1, 16'h2222, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      logic        exp_we;
      logic [31:0] exp_a;
      logic [15:0] exp_d;
      exp_we = 1'b0; exp_a = 32'd0; exp_d = 16'h0;
      case (k)
        2: begin exp_we = 1'b1; exp_a = 32'd0;   exp_d = 16'h1111; end
        3: begin exp_we = 1'b1; exp_a = 32'd2;   exp_d = 16'h1111; end
        4: begin exp_we = 1'b1; exp_a = 32'd4;   exp_d = 16'h1111; end
        7: begin exp_we = 1'b1; exp_a = 32'd644; exp_d = 16'h2222; end
        8: begin exp_we = 1'b1; exp_a = 32'd646; exp_d = 16'h2222; end
        default: ;
      endcase
      check($sformatf("b2b_we_k%0d", k), 32'(write_enable), 32'(exp_we));
      if (exp_we) begin
        check($sformatf("b2b_addr_k%0d", k), write_addr, exp_a);
        check($sformatf("b2b_data_k%0d", k), 32'(write_data), 32'(exp_d));
      end
      check($sformatf("b2b_done_k%0d", k), 32'(done), (k == 5 || k == 9) ? 32'd1 : 32'd0);
      if (k == 5) check("b2b_ready_k5", 32'(cmd_ready), 32'd1);
      tick();
      if (k == 5) cmd_valid = 1'b0;
    end

    // Reset asserted during the fill of a 10x10 rectangle
    drive_cmd(9'd0, 8'd0, 9'd10, 8'd10, 16'h7777, 1'b1);
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    check("mid_we_before_rst", 32'(write_enable), 32'd1);
    rst_in = 1'b1;
    tick();
    check("mid_rst_we", 32'(write_enable), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_swap", 32'(swap_buffer), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_addr", write_addr, 32'd0);
    rst_in = 1'b0;
    #1;
    check("mid_rst_release_ready", 32'(cmd_ready), 32'd1);
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (write_enable || swap_buffer || done || busy) stray++;
      end
      check("mid_rst_quiet", 32'(stray), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
